coh_snoop_resp: RTL and testbench
=================================

Name: coh_snoop_resp

Overview:
- Cache-side responder for the dual-core coherence bus, instantiated once inside each dcache.
- Answers snoops from the coherence controller:
  - looks up the snooped block in the cache's tag array;
  - reports a Modified hit on ccwrite;
  - writes the dirty block back (two words) over the cache's data port;
  - applies the MSI state change (M->S, or ->I on invalidate) when the controller releases ccwait.
- The owning dcache stalls its own FSM while snoop_busy=1 and muxes the snp_* signals onto its ccif data port.

Parameters:
SETS, 8, number of sets (index width = log2(SETS) = 3)
WAYS, 2, associativity (way index width = 1)
TAGW, 26, tag width; address = tag[31:6], idx[5:3], blkoff[2], byteoff[1:0]

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
ccwait  in  1  controller holds this cache for a snoop
ccinv  in  1  controller requests invalidate (BusRdX)
ccsnoopaddr  in  32  snooped address
ccwrite  out  1  snoop hit on dirty (M) block; data will be supplied
snoop_busy  out  1  responder owns cache; dcache FSM must stall
snp_dWEN  out  1  write-back request to controller
snp_daddr  out  32  write-back word address
snp_dstore  out  32  write-back data
dwait  in  1  controller/RAM handshake, 0 = word accepted this cycle
tag_idx  out  3  tag/data array read index (combinational read)
tag_rdtag  in  WAYS*TAGW  tags at tag_idx
tag_rdvalid  in  WAYS  valid bits at tag_idx
tag_rddirty  in  WAYS  dirty bits at tag_idx
data_way  out  1  data read way
data_off  out  1  data read word offset
data_rdword  in  32  data word at {tag_idx, data_way, data_off}
upd_en  out  1  one-cycle state write strobe
upd_way  out  1  way to update
upd_valid  out  1  new valid bit
upd_dirty  out  1  new dirty bit (always 0)

Behaviour:
- States: IDLE, LOOKUP, FLUSH0, FLUSH1, HOLD.
- Reset (asynchronous, RST=1): state=IDLE; all registers clear; every output 0. A reset mid-flush abandons the write-back and performs no update.
- IDLE:
  - ccwait=1 -> register snoop address into addr_r, clear inv_r, go LOOKUP.
  - Outputs 0, except snoop_busy = ccwait.
- inv_r sets on any cycle in LOOKUP, FLUSH0, FLUSH1 or HOLD with ccinv=1; it never clears until IDLE.
- tag_idx = addr_r[5:3] in every non-IDLE state.
- Hit detection (LOOKUP): hit if some way w has tag_rdvalid[w]=1 and tag_rdtag[w]==addr_r[31:6]; lowest matching way wins.
  - hw_r = hit way, hd_r = tag_rddirty[hw_r], hit_r = hit; all registered at end of LOOKUP.
- LOOKUP (exactly one cycle):
  - ccwrite = hit & dirty, combinationally.
  - Next state: hit&dirty -> FLUSH0; otherwise HOLD.
- FLUSH0 / FLUSH1:
  - ccwrite=1; snp_dWEN=1.
  - snp_daddr = {addr_r[31:3], off, 2'b00}, with off=0 in FLUSH0 and 1 in FLUSH1.
  - data_way=hw_r, data_off=off, snp_dstore=data_rdword.
  - Outputs hold stable while dwait=1.
  - dwait=0 advances FLUSH0->FLUSH1 and FLUSH1->HOLD.
- HOLD: ccwrite=hd_r&hit_r; all snp_* are 0; waits for ccwait=0.
- Release (ccwait=0 seen in HOLD): go IDLE, and in that same cycle upd_en=hit_r, upd_way=hw_r, upd_dirty=0, upd_valid=~(inv_r|ccinv).
  - Result: M->S, S->S, M/S->I on invalidate; a miss makes no update.
- Abort: ccwait=0 in LOOKUP, FLUSH0 or FLUSH1 -> IDLE immediately with no update and no further snp_dWEN.
- snoop_busy=1 in every non-IDLE state.
- Back-to-back snoops: ccwait=1 in the IDLE cycle right after release starts a new LOOKUP.

Test Plan:
- Miss: idx 3 with no matching tag, ccwait 1 for 3 cycles, ccinv=0 -> ccwrite=0 throughout; upd_en never asserts; snoop_busy low one cycle after ccwait falls.
- Clean hit + invalidate: way1 tag 0x0000123, idx 2 valid and clean; snoop 0x000048D0 with ccinv=1 in LOOKUP -> ccwrite=0; on release upd_en=1, upd_way=1, upd_valid=0, upd_dirty=0.
- Dirty hit, read share: way0 dirty, words 0xDEADBEEF/0xCAFEF00D; snoop 0x00001008; dwait=1 for 2 cycles per word -> ccwrite=1 in LOOKUP; snp_daddr 0x00001008 then 0x0000100C; snp_dstore matches each word; release gives upd_valid=1, upd_dirty=0.
- Dirty hit with late invalidate: as above, but ccinv rises only in HOLD -> write-back of both words completes; release gives upd_valid=0.
- Abort: ccwait drops in FLUSH0 while dwait=1 -> next cycle IDLE, snp_dWEN=0, upd_en=0.
- Reset mid-flush: RST pulses in FLUSH1 -> all outputs 0 in the same cycle (asynchronous); a following ccwait starts a fresh LOOKUP.

Source files
------------

// File: rtl/coh_snoop_resp_if.sv
// Snoop responder bus bundle: coherence-controller snoop handshake, write-back
// data port, tag/data array read port and tag-state update strobe.
//   slave  : the responder (coh_snoop_resp)
//   master : the surrounding dcache / controller side
interface coh_snoop_resp_if #(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2,
  parameter int unsigned TAGW = 26
);
  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Snoop handshake
  logic                   ccwait;
  logic                   ccinv;
  logic [31:0]            ccsnoopaddr;
  logic                   ccwrite;
  logic                   snoop_busy;
  // Write-back port
  logic                   snp_dWEN;
  logic [31:0]            snp_daddr;
  logic [31:0]            snp_dstore;
  logic                   dwait;
  // Tag/data array read
  logic [IDXW-1:0]        tag_idx;
  logic [WAYS*TAGW-1:0]   tag_rdtag;
  logic [WAYS-1:0]        tag_rdvalid;
  logic [WAYS-1:0]        tag_rddirty;
  logic [WAYW-1:0]        data_way;
  logic                   data_off;
  logic [31:0]            data_rdword;
  // Tag-state update
  logic                   upd_en;
  logic [WAYW-1:0]        upd_way;
  logic                   upd_valid;
  logic                   upd_dirty;

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
           tag_rdtag, tag_rdvalid, tag_rddirty, data_rdword,
    output ccwrite, snoop_busy, snp_dWEN, snp_daddr, snp_dstore,
           tag_idx, data_way, data_off,
           upd_en, upd_way, upd_valid, upd_dirty
  );

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait,
           tag_rdtag, tag_rdvalid, tag_rddirty, data_rdword,
    input  ccwrite, snoop_busy, snp_dWEN, snp_daddr, snp_dstore,
           tag_idx, data_way, data_off,
           upd_en, upd_way, upd_valid, upd_dirty
  );
endinterface

// File: rtl/coh_snoop_resp.sv
// Cache-side snoop responder: looks up a snooped block, flags a Modified hit on
// ccwrite, writes the two-word dirty block back, and applies the MSI downgrade
// (M->S, or ->I on invalidate) when the controller drops ccwait.
// Ports: CLK, RST (async, active-high), bus (coh_snoop_resp_if.slave).
module coh_snoop_resp #(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2,
  parameter int unsigned TAGW = 26
) (
  input  logic                CLK,
  input  logic                RST,
  coh_snoop_resp_if.slave     bus
);
  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BLKW = 29;  // word-pair address bits [31:3]

  typedef enum logic [2:0] {IDLE, LOOKUP, FLUSH0, FLUSH1, HOLD} state_t;

  state_t            state, state_n;
  logic [BLKW-1:0]   blk_r, blk_n;
  logic              inv_r, inv_n;
  logic [WAYW-1:0]   hw_r, hw_n;
  logic              hd_r, hd_n;
  logic              hit_r, hit_n;

  logic              hit_c;
  logic [WAYW-1:0]   hw_c;
  logic              hd_c;
  logic              off_c;
  logic              unused_addr_lo;

  // Byte/word offset of the snooped address is irrelevant: whole block is handled.
  assign unused_addr_lo = ^bus.ccsnoopaddr[2:0];

  // Tag compare against the registered snoop address; lowest matching way wins.
  always_comb begin
    hit_c = 1'b0;
    hw_c  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_c && bus.tag_rdvalid[w] &&
          (bus.tag_rdtag[w*TAGW +: TAGW] == blk_r[BLKW-1 -: TAGW])) begin
        hit_c = 1'b1;
        hw_c  = WAYW'(w);
      end
    end
    hd_c = bus.tag_rddirty[hw_c];
  end

  // State and snoop-context registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      blk_r <= '0;
      inv_r <= 1'b0;
      hw_r  <= '0;
      hd_r  <= 1'b0;
      hit_r <= 1'b0;
    end else begin
      state <= state_n;
      blk_r <= blk_n;
      inv_r <= inv_n;
      hw_r  <= hw_n;
      hd_r  <= hd_n;
      hit_r <= hit_n;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_n        = state;
    blk_n          = blk_r;
    inv_n          = inv_r;
    hw_n           = hw_r;
    hd_n           = hd_r;
    hit_n          = hit_r;
    off_c          = 1'b0;
    bus.ccwrite    = 1'b0;
    bus.snoop_busy = 1'b0;
    bus.snp_dWEN   = 1'b0;
    bus.snp_daddr  = '0;
    bus.snp_dstore = '0;
    bus.tag_idx    = '0;
    bus.data_way   = '0;
    bus.data_off   = 1'b0;
    bus.upd_en     = 1'b0;
    bus.upd_way    = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_dirty  = 1'b0;

    if (state != IDLE) begin
      bus.snoop_busy = 1'b1;
      bus.tag_idx    = blk_r[IDXW-1:0];
      // Invalidate request is sticky for the rest of the snoop.
      if (bus.ccinv) inv_n = 1'b1;
    end

    case (state)
      IDLE: begin
        // Gate with RST so every output reads 0 while reset is held.
        bus.snoop_busy = bus.ccwait & ~RST;
        if (bus.ccwait) begin
          blk_n   = bus.ccsnoopaddr[31:3];
          inv_n   = 1'b0;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.ccwrite = hit_c & hd_c;
        hw_n        = hw_c;
        hd_n        = hd_c;
        hit_n       = hit_c;
        if (!bus.ccwait)          state_n = IDLE;
        else if (hit_c && hd_c)   state_n = FLUSH0;
        else                      state_n = HOLD;
      end
      FLUSH0, FLUSH1: begin
        off_c          = (state == FLUSH1);
        bus.ccwrite    = 1'b1;
        bus.snp_dWEN   = 1'b1;
        bus.snp_daddr  = {blk_r, off_c, 2'b00};
        bus.data_way   = hw_r;
        bus.data_off   = off_c;
        bus.snp_dstore = bus.data_rdword;
        if (!bus.ccwait)     state_n = IDLE;
        else if (!bus.dwait) state_n = (state == FLUSH0) ? FLUSH1 : HOLD;
      end
      HOLD: begin
        bus.ccwrite = hd_r & hit_r;
        if (!bus.ccwait) begin
          state_n       = IDLE;
          bus.upd_en    = hit_r;
          bus.upd_way   = hw_r;
          bus.upd_valid = ~(inv_r | bus.ccinv);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_coh_snoop_resp.sv
// Self-checking bench for coh_snoop_resp: a behavioural cache-array model
// drives the tag/data read ports; each snoop's cycle-by-cycle outcome is
// predicted from the MSI snoop rules and compared with immediate assertions.
module tb_coh_snoop_resp;
  logic CLK = 1'b0;
  logic RST;
  int   n_chk;
  int   n_fail;

  logic [25:0] tag_m   [8][2];
  logic        val_m   [8][2];
  logic        dirty_m [8][2];
  logic [31:0] data_m  [8][2][2];

  coh_snoop_resp_if #(.SETS(8), .WAYS(2), .TAGW(26)) bus ();

  coh_snoop_resp #(.SETS(8), .WAYS(2), .TAGW(26)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial forever #5 CLK = ~CLK;

  // Cache arrays as seen through the combinational read port.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      bus.tag_rdtag[w*26 +: 26] = tag_m[bus.tag_idx][w];
      bus.tag_rdvalid[w]        = val_m[bus.tag_idx][w];
      bus.tag_rddirty[w]        = dirty_m[bus.tag_idx][w];
    end
    bus.data_rdword = data_m[bus.tag_idx][bus.data_way][bus.data_off];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_lookup(input logic [31:0] a, output logic hit, output int way);
    logic [2:0] idx;
    idx = a[5:3];
    hit = 1'b0;
    way = 0;
    for (int w = 0; w < 2; w++) begin
      if (!hit && val_m[idx][w] && tag_m[idx][w] == a[31:6]) begin
        hit = 1'b1;
        way = w;
      end
    end
  endfunction

  task automatic fill(input int s, input int w, input logic [25:0] t,
                      input logic v, input logic d, input logic [31:0] w0, input logic [31:0] w1);
    tag_m[s][w]     = t;
    val_m[s][w]     = v;
    dirty_m[s][w]   = d;
    data_m[s][w][0] = w0;
    data_m[s][w][1] = w1;
  endtask

  // One IDLE cycle with no snoop pending.
  task automatic idle_check(input string tag);
    @(negedge CLK);
    bus.ccwait = 1'b0;
    bus.ccinv  = 1'b0;
    bus.dwait  = 1'b1;
    #1;
    chk({tag, "_busy"},    32'(bus.snoop_busy), 32'd0);
    chk({tag, "_ccwrite"}, 32'(bus.ccwrite),    32'd0);
    chk({tag, "_dwen"},    32'(bus.snp_dWEN),   32'd0);
    chk({tag, "_upd"},     32'(bus.upd_en),     32'd0);
  endtask

  // Full snoop starting in IDLE and ending in the release cycle.
  // mode: 0 no invalidate, 1 ccinv from start, 2 ccinv only in HOLD, 3 only at release.
  task automatic snoop(input logic [31:0] a, input int mode, input int stall, input int hold);
    logic       hit, dirty;
    int         way, nwr;
    logic [2:0] idx;
    idx = a[5:3];
    model_lookup(a, hit, way);
    dirty = hit && dirty_m[idx][way];
    nwr   = 0;

    @(negedge CLK);
    bus.ccwait      = 1'b1;
    bus.ccsnoopaddr = a;
    bus.ccinv       = (mode == 1);
    bus.dwait       = 1'b1;
    #1;
    chk("idle_busy", 32'(bus.snoop_busy), 32'd1);

    @(negedge CLK);
    bus.ccsnoopaddr = $urandom;
    #1;
    chk("lookup_ccwrite", 32'(bus.ccwrite), 32'(hit && dirty));
    chk("lookup_tag_idx", 32'(bus.tag_idx), 32'(idx));
    chk("lookup_busy",    32'(bus.snoop_busy), 32'd1);

    if (hit && dirty) begin
      for (int off = 0; off < 2; off++) begin
        for (int s = 0; s <= stall; s++) begin
          @(negedge CLK);
          bus.dwait = (s < stall);
          #1;
          chk("wb_dwen",    32'(bus.snp_dWEN), 32'd1);
          chk("wb_daddr",   bus.snp_daddr, {a[31:3], 3'b000} + 32'(off * 4));
          chk("wb_dstore",  bus.snp_dstore, data_m[idx][way][off]);
          chk("wb_ccwrite", 32'(bus.ccwrite), 32'd1);
          if (bus.snp_dWEN && !bus.dwait) nwr++;
        end
      end
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      bus.dwait = 1'b1;
      bus.ccinv = (mode == 1) || (mode == 2);
      #1;
      chk("hold_ccwrite", 32'(bus.ccwrite), 32'(hit && dirty));
      chk("hold_dwen",    32'(bus.snp_dWEN), 32'd0);
      chk("hold_upd",     32'(bus.upd_en), 32'd0);
    end

    @(negedge CLK);
    bus.ccwait = 1'b0;
    bus.dwait  = 1'b1;
    bus.ccinv  = (mode != 0);
    #1;
    chk("rel_busy",   32'(bus.snoop_busy), 32'd1);
    chk("rel_dwen",   32'(bus.snp_dWEN), 32'd0);
    chk("rel_upd_en", 32'(bus.upd_en), 32'(hit));
    if (hit) begin
      chk("rel_upd_way",   32'(bus.upd_way), 32'(way));
      chk("rel_upd_valid", 32'(bus.upd_valid), 32'(mode == 0));
      chk("rel_upd_dirty", 32'(bus.upd_dirty), 32'd0);
      val_m[idx][way]   = (mode == 0);
      dirty_m[idx][way] = 1'b0;
    end
    chk("wb_words", 32'(nwr), (hit && dirty) ? 32'd2 : 32'd0);
    bus.ccinv = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    n_chk           = 0;
    n_fail          = 0;
    RST             = 1'b1;
    bus.ccwait      = 1'b1;
    bus.ccinv       = 1'b0;
    bus.ccsnoopaddr = '0;
    bus.dwait       = 1'b1;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++)
        fill(s, w, 26'h3FF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset: every output 0 even with ccwait held high.
    @(negedge CLK);
    #1;
    chk("rst_busy",    32'(bus.snoop_busy), 32'd0);
    chk("rst_ccwrite", 32'(bus.ccwrite), 32'd0);
    chk("rst_dwen",    32'(bus.snp_dWEN), 32'd0);
    chk("rst_upd",     32'(bus.upd_en), 32'd0);
    chk("rst_tag_idx", 32'(bus.tag_idx), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    bus.ccwait = 1'b0;
    idle_check("post_rst");

    // Miss in set 3.
    fill(3, 0, 26'h11, 1'b1, 1'b1, 32'h1, 32'h2);
    fill(3, 1, 26'h22, 1'b1, 1'b0, 32'h3, 32'h4);
    snoop({26'h33, 3'd3, 3'b000}, 0, 0, 1);
    idle_check("miss_after");

    // Clean hit in way 1 with invalidate.
    fill(2, 0, 26'h77, 1'b1, 1'b0, 32'h5, 32'h6);
    fill(2, 1, 26'h123, 1'b1, 1'b0, 32'h7, 32'h8);
    snoop(32'h0000_48D0, 1, 0, 1);
    idle_check("clean_inv_after");

    // Dirty hit, read share; then a back-to-back snoop finds it clean.
    fill(1, 0, 26'h40, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    snoop(32'h0000_1008, 0, 2, 1);
    snoop(32'h0000_1008, 0, 0, 1);
    idle_check("b2b_after");

    // Dirty hit with invalidate arriving only in HOLD.
    dirty_m[1][0] = 1'b1;
    snoop(32'h0000_1008, 2, 2, 2);
    idle_check("late_inv_after");

    // Abort while stalled in FLUSH0.
    fill(5, 0, 26'h2AA, 1'b0, 1'b0, 32'h9, 32'hA);
    fill(5, 1, 26'h2AA, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    a = {26'h2AA, 3'd5, 3'b000};
    @(negedge CLK); bus.ccwait = 1'b1; bus.ccsnoopaddr = a; bus.dwait = 1'b1; #1;
    @(negedge CLK); #1;
    chk("ab_lookup_ccwrite", 32'(bus.ccwrite), 32'd1);
    @(negedge CLK); #1;
    chk("ab_f0_dwen",  32'(bus.snp_dWEN), 32'd1);
    chk("ab_f0_daddr", bus.snp_daddr, a);
    @(negedge CLK); bus.ccwait = 1'b0; #1;
    chk("ab_drop_upd", 32'(bus.upd_en), 32'd0);
    @(negedge CLK); #1;
    chk("ab_busy",    32'(bus.snoop_busy), 32'd0);
    chk("ab_dwen",    32'(bus.snp_dWEN), 32'd0);
    chk("ab_upd",     32'(bus.upd_en), 32'd0);
    chk("ab_ccwrite", 32'(bus.ccwrite), 32'd0);

    // Reset pulse in FLUSH1: outputs clear at once, then a fresh snoop works.
    @(negedge CLK); bus.ccwait = 1'b1; bus.ccsnoopaddr = a; bus.dwait = 1'b1; #1;
    @(negedge CLK); #1;
    @(negedge CLK); bus.dwait = 1'b0; #1;
    chk("rf_f0_dstore", bus.snp_dstore, 32'h1234_5678);
    @(negedge CLK); bus.dwait = 1'b1; #1;
    chk("rf_f1_daddr",  bus.snp_daddr, a + 32'd4);
    chk("rf_f1_dstore", bus.snp_dstore, 32'h9ABC_DEF0);
    RST = 1'b1;
    #1;
    chk("rf_busy",    32'(bus.snoop_busy), 32'd0);
    chk("rf_ccwrite", 32'(bus.ccwrite), 32'd0);
    chk("rf_dwen",    32'(bus.snp_dWEN), 32'd0);
    chk("rf_daddr",   bus.snp_daddr, 32'd0);
    chk("rf_upd",     32'(bus.upd_en), 32'd0);
    chk("rf_tag_idx", 32'(bus.tag_idx), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    bus.ccwait = 1'b0;
    #1;
    chk("rf_idle_busy", 32'(bus.snoop_busy), 32'd0);
    snoop(a, 0, 1, 0);
    idle_check("rf_after");

    // Randomized snoops over a small tag pool so hits, duplicate tags and
    // dirty blocks are all frequent.
    for (int it = 0; it < 60; it++) begin
      int s;
      s = int'($urandom_range(0, 7));
      for (int w = 0; w < 2; w++)
        fill(s, w, 26'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
             1'($urandom), $urandom, $urandom);
      a = {26'($urandom_range(0, 3)), 3'(s), 3'($urandom)};
      snoop(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle_check("rnd_idle");
    end
    idle_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
